// File: rtl/clock_ctrl_pkg.sv
// Shared types for the breadboard CPU clock controller.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: mode_e (mode input encoding), state_e (clock FSM states).
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL  = 2'b00,
    MODE_ASTABLE = 2'b01,
    MODE_BURST   = 2'b10,
    MODE_STOP    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    S_HIGH = 2'b01,
    S_HALT = 2'b10
  } state_e;

endpackage

// File: rtl/push_debouncer.sv
// Synchronises and debounces the raw step button; emits clean level and a rise strobe.
// Latency: 2 sync cycles + DEBOUNCE stable cycles to level change; rise strobe in the same cycle as level.
// Backpressure: none; strobe is a one-cycle pulse with no handshake.
// Ports: clk, rst (sync active-high), push (raw async) -> level (debounced), rise (0->1 strobe).
module push_debouncer #(
  parameter int DEBOUNCE = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             rise_q,  rise_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Counter tracks consecutive cycles the synchronised input differs from the
  // accepted level; any return to the accepted level restarts it.
  always_comb begin
    sync1_d = push;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/clock_control_unit.sv
// CPU clock generator: manual step, astable, counted burst, stop; glitch-free halt (no runt high phases).
// Latency: clk_out/clk_rise registered, change one cycle after the deciding input is sampled.
// Backpressure: hlt stalls clock after the current high phase completes; burst_start ignored while busy.
// Ports: clk, rst, mode[1:0], hlt, push, half_period[DIV_W], burst_len[BURST_W], burst_start
//        -> clk_out, clk_rise, halted, burst_busy (+ cycle_count[31:0] when CLK_CYCLE_COUNT_EN is defined).
module clock_control_unit
  import clock_ctrl_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int BURST_W   = 8,
  parameter int DEBOUNCE  = 1000,
  parameter int PULSE_CYC = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               hlt,
  input  logic               push,
  input  logic [DIV_W-1:0]   half_period,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               burst_start,
  output logic               clk_out,
  output logic               clk_rise,
  output logic               halted,
  output logic               burst_busy
`ifdef CLK_CYCLE_COUNT_EN
  ,
  output logic [31:0]        cycle_count
`endif
);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               burst_busy_q, burst_busy_d;
  logic               clk_out_q, clk_out_d;
  logic               clk_rise_q, clk_rise_d;
  logic               halted_q, halted_d;

  mode_e              mode_s;
  logic [DIV_W-1:0]   hp_eff;
  logic               phase_end;
  logic               go_high;
  logic               push_level;
  logic               push_rise;
  logic               step_req;

  push_debouncer #(.DEBOUNCE(DEBOUNCE)) u_push_debouncer (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .level (push_level),
    .rise  (push_rise)
  );

  assign mode_s    = mode_e'(mode);
  assign hp_eff    = (half_period == '0) ? DIV_W'(1) : half_period;
  // Reset leaves div at 0, so treat 0 like 1 to avoid a stuck phase.
  assign phase_end = (div_q <= DIV_W'(1));
  assign step_req  = push_rise & push_level;

  // Next-state logic. burst_cnt holds the number of high phases still to start.
  always_comb begin
    state_d      = state_q;
    div_d        = phase_end ? div_q : div_q - DIV_W'(1);
    burst_cnt_d  = burst_cnt_q;
    burst_busy_d = burst_busy_q;
    go_high      = 1'b0;
    case (state_q)
      S_LOW: begin
        if (mode_s != MODE_BURST) begin
          burst_busy_d = 1'b0;
          burst_cnt_d  = '0;
        end
        if (mode_s == MODE_BURST && !burst_busy_q && burst_start && burst_len != '0) begin
          burst_busy_d = 1'b1;
          // Accepted under hlt: keep the first period pending until release.
          if (hlt) begin
            burst_cnt_d = burst_len;
          end else begin
            burst_cnt_d = burst_len - BURST_W'(1);
            go_high     = 1'b1;
          end
        end else if (!hlt) begin
          case (mode_s)
            MODE_BURST: begin
              if (burst_busy_q && phase_end) begin
                if (burst_cnt_q == '0) begin
                  burst_busy_d = 1'b0;
                end else begin
                  burst_cnt_d = burst_cnt_q - BURST_W'(1);
                  go_high     = 1'b1;
                end
              end
            end
            MODE_ASTABLE: go_high = phase_end;
            MODE_MANUAL:  go_high = step_req;
            default:      go_high = 1'b0;
          endcase
        end
        if (hlt) begin
          state_d = S_HALT;
        end else if (go_high) begin
          state_d = S_HIGH;
          div_d   = (mode_s == MODE_MANUAL) ? DIV_W'(PULSE_CYC) : hp_eff;
        end
      end
      S_HIGH: begin
        // High phase always runs to its loaded length; hlt only acts afterwards.
        if (phase_end) begin
          state_d = hlt ? S_HALT : S_LOW;
          div_d   = hp_eff;
        end
      end
      S_HALT: begin
        if (!hlt) begin
          state_d = S_LOW;
          div_d   = hp_eff;
        end
      end
      default: begin
        state_d = S_LOW;
        div_d   = hp_eff;
      end
    endcase
  end

  // Output logic: registered versions of the next state.
  always_comb begin
    clk_out_d  = (state_d == S_HIGH);
    clk_rise_d = (state_d == S_HIGH) && (state_q != S_HIGH);
    halted_d   = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LOW;
      div_q        <= '0;
      burst_cnt_q  <= '0;
      burst_busy_q <= 1'b0;
      clk_out_q    <= 1'b0;
      clk_rise_q   <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      burst_cnt_q  <= burst_cnt_d;
      burst_busy_q <= burst_busy_d;
      clk_out_q    <= clk_out_d;
      clk_rise_q   <= clk_rise_d;
      halted_q     <= halted_d;
    end
  end

  assign clk_out    = clk_out_q;
  assign clk_rise   = clk_rise_q;
  assign halted     = halted_q;
  assign burst_busy = burst_busy_q;

`ifdef CLK_CYCLE_COUNT_EN
  logic [31:0] cycle_count_q, cycle_count_d;

  // Advances together with clk_rise so both outputs move on the same edge.
  always_comb begin
    cycle_count_d = cycle_count_q + {31'd0, clk_rise_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
    end
  end

  assign cycle_count = cycle_count_q;
`endif

endmodule
